// File: rtl/tdm_serializer.sv
// tdm_serializer: round-robin 4-channel word arbiter feeding an MSB-first serial line with demux selects
module tdm_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ch_data0,
    input  logic [DATA_W-1:0] ch_data1,
    input  logic [DATA_W-1:0] ch_data2,
    input  logic [DATA_W-1:0] ch_data3,
    input  logic [3:0]        ch_valid,
    output logic [3:0]        ch_ready,
    output logic              ser_out,
    output logic              sel0,
    output logic              sel1,
    output logic              ser_valid,
    output logic              frame_start
);
    localparam int CNT_W = $clog2(DATA_W);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t             state, state_nx;
    logic [1:0]         rr_ptr, gnt_idx;
    logic               gnt_any, accept;
    logic [DATA_W-1:0]  sh, gnt_word;
    logic [CNT_W-1:0]   cnt;
    // lowest offset from rr_ptr wins, so scan offsets downward and let the last hit stand
    always_comb begin
        gnt_idx = rr_ptr;
        for (int k = 3; k >= 0; k--)
            if (ch_valid[rr_ptr + 2'(k)]) gnt_idx = rr_ptr + 2'(k);
    end
    assign gnt_any     = |ch_valid;
    assign accept      = state == IDLE && gnt_any;
    assign ch_ready    = (rst_n && accept) ? 4'b0001 << gnt_idx : 4'b0000;
    assign gnt_word    = gnt_idx == 2'd0 ? ch_data0 :
                         gnt_idx == 2'd1 ? ch_data1 :
                         gnt_idx == 2'd2 ? ch_data2 : ch_data3;
    assign ser_valid   = state == SHIFT;
    assign ser_out     = ser_valid & sh[DATA_W-1];
    assign frame_start = ser_valid && cnt == CNT_W'(DATA_W-1);
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = gnt_any ? SHIFT : IDLE;
        else               state_nx = cnt == '0 ? IDLE : SHIFT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 2'd0;
            sh     <= '0;
            cnt    <= '0;
            sel0   <= 1'b0;
            sel1   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sh           <= gnt_word;
                {sel1, sel0} <= gnt_idx;
                cnt          <= CNT_W'(DATA_W-1);
            end else if (state == SHIFT) begin
                sh  <= sh << 1;
                cnt <= cnt - 1'b1;
                if (cnt == '0) rr_ptr <= {sel1, sel0} + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_tdm_serializer.sv
// tb_tdm_serializer: directed checks of arbitration, serial timing, selects and reset behaviour
module tb_tdm_serializer;
    logic       clk, rst_n;
    logic [7:0] ch_data0, ch_data1, ch_data2, ch_data3;
    logic [3:0] ch_valid, ch_ready;
    logic       ser_out, sel0, sel1, ser_valid, frame_start;
    int         checks = 0, errors = 0;

    tdm_serializer #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_data0(ch_data0), .ch_data1(ch_data1), .ch_data2(ch_data2), .ch_data3(ch_data3),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ser_out(ser_out),
        .sel0(sel0), .sel1(sel1), .ser_valid(ser_valid), .frame_start(frame_start)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] w;
    int         cyc;

    initial begin
        rst_n = 0; ch_valid = 4'b1111;
        ch_data0 = 0; ch_data1 = 0; ch_data2 = 0; ch_data3 = 0;
        step(2);
        chk("reset_outputs", {ser_out, ser_valid, frame_start, sel1, sel0, ch_ready}, 0);
        ch_valid = 0;
        rst_n = 1;
        step();
        chk("idle_no_valid", {ser_out, ser_valid, ch_ready}, 0);

        // single word on channel 2
        ch_data2 = 8'hA5; ch_valid = 4'b0100; w = 8'hA5;
        #1;
        chk("single_ready", ch_ready, 4'b0100);
        step();
        ch_valid = 0;
        #1;
        chk("single_ready_drop", ch_ready, 0);
        chk("single_sel", {sel1, sel0}, 2'b10);
        for (int i = 0; i < 8; i++) begin
            chk("single_bit", ser_out, w[7-i]);
            chk("single_valid", ser_valid, 1);
            chk("single_frame", frame_start, i == 0);
            chk("single_out2", ser_out & sel1 & ~sel0, w[7-i]);
            step();
        end
        chk("single_after", {ser_out, ser_valid}, 0);

        // word on channel 3, then long idle
        ch_data3 = 8'h3C; ch_valid = 4'b1000;
        #1;
        chk("ch3_ready", ch_ready, 4'b1000);
        step();
        ch_valid = 0;
        step(8);
        for (int i = 0; i < 20; i++) begin
            chk("idle_hold", {ser_out, ser_valid, ch_ready, sel1, sel0}, 8'b00000011);
            step();
        end

        // round-robin with all channels valid, pointer now 0
        ch_data0 = 8'h01; ch_data1 = 8'h02; ch_data2 = 8'h04; ch_data3 = 8'h08;
        ch_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            chk("rr_ready", ch_ready, 4'b0001 << (n % 4));
            step();
            chk("rr_sel", {sel1, sel0}, n % 4);
            chk("rr_frame", frame_start, 1);
            if (n == 4) break;
            cyc = 0;
            while (ch_ready == 0 && cyc < 20) begin
                step();
                cyc++;
            end
            chk("rr_gap", cyc + 1, 9);
        end
        ch_valid = 0;
        step(8);

        // serve channel 1, then pointer must skip to 0
        ch_valid = 4'b0010;
        #1;
        chk("skip_ch1", ch_ready, 4'b0010);
        step();
        ch_valid = 0;
        step(8);
        ch_data0 = 8'hFF; ch_valid = 4'b0011;
        #1;
        chk("skip_ptr", ch_ready, 4'b0001);
        step();
        ch_valid = 0; ch_data0 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("stable_bit", {ser_valid, ser_out}, 2'b11);
            step();
        end
        chk("stable_end", ser_valid, 0);

        // reset in mid-word
        ch_data2 = 8'hA5; ch_valid = 4'b0100;
        step();
        ch_valid = 4'b1111;
        step(3);
        chk("mid_shifting", ser_valid, 1);
        rst_n = 0;
        #1;
        chk("mid_reset_outputs", {ser_out, ser_valid, frame_start, sel1, sel0, ch_ready}, 0);
        step(2);
        rst_n = 1;
        #1;
        chk("post_reset_ptr", ch_ready, 4'b0001);
        step();
        chk("post_reset_sel", {sel1, sel0}, 2'b00);
        ch_valid = 0;
        step(9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
